// File: rtl/instr_fetch_unit_pkg.sv
// Shared types for the fetch stage: FSM states, buffered fetch entry and the
// processor state enum used by proc.
package instr_fetch_unit_pkg;

  localparam int FE_ADDR_W = 8;
  localparam int FE_DATA_W = 8;

  typedef enum logic {
    FE_IDLE,
    FE_RUN
  } fetch_state_t;

  typedef struct packed {
    logic [FE_ADDR_W-1:0] pc;
    logic [FE_DATA_W-1:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    PS_RESET,
    PS_FETCH,
    PS_EXEC,
    PS_HALT
  } processor_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read port plus the valid/ready instruction stream to proc.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) ();

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    output instr,
    output instr_pc,
    output instr_valid,
    input  instr_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    input  instr,
    input  instr_pc,
    input  instr_valid,
    output instr_ready
  );

endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// Prefetch buffer of PC-tagged instructions; pointers carry a wrap bit so
// full and empty are distinguishable without a separate counter.
module instr_fetch_unit_fifo
  import instr_fetch_unit_pkg::*;
#(
  parameter int BUF_DEPTH = 4,
  localparam int AW       = $clog2(BUF_DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  fetch_entry_t i_entry,
  input  logic         i_pop,
  input  logic         i_flush,
  output fetch_entry_t o_head,
  output logic [AW:0]  o_count,
  output logic         o_empty
);

  fetch_entry_t r_mem [BUF_DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_entry;
  end

  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];
  assign o_count = r_wr_ptr - r_rd_ptr;
  assign o_empty = (r_wr_ptr == r_rd_ptr);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues single-cycle-latency reads to instruction
// memory and queues the PC-tagged results for proc; redirect flushes everything.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int ADDR_W    = FE_ADDR_W,
  parameter int DATA_W    = FE_DATA_W,
  parameter int BUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  instr_fetch_unit_if.master bus
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(BUF_DEPTH);

  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic              r_inflight;
  logic [ADDR_W-1:0] r_tag_pc;
  logic              w_issue;
  logic              w_pop;
  logic              w_push;
  logic [CW:0]       w_occ;
  logic [CW-1:0]     w_count;
  logic              w_empty;
  fetch_entry_t      w_head;
  fetch_entry_t      w_entry;

  assign w_pop = !w_empty && bus.instr_ready;
  // Occupancy counts the in-flight read so a returning byte always has a slot.
  assign w_occ = {1'b0, w_count} + (CW+1)'(r_inflight) - (CW+1)'(w_pop);

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      FE_IDLE: begin
        if (fetch_en) w_state_nxt = FE_RUN;
      end
      FE_RUN: begin
        if (!fetch_en) w_state_nxt = FE_IDLE;
        w_issue = !redirect && (w_occ < DEPTH_C);
      end
      default: w_state_nxt = FE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= FE_IDLE;
      r_pc       <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_issue;
      if (redirect)     r_pc <= redirect_pc;
      else if (w_issue) r_pc <= r_pc + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_issue) r_tag_pc <= r_pc;
  end

  // Return stage: a redirect in the return cycle discards the stale byte.
  assign w_push        = r_inflight && !redirect;
  assign w_entry.pc    = r_tag_pc;
  assign w_entry.instr = bus.imem_rdata;

  instr_fetch_unit_fifo #(
    .BUF_DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_entry (w_entry),
    .i_pop   (w_pop),
    .i_flush (redirect),
    .o_head  (w_head),
    .o_count (w_count),
    .o_empty (w_empty)
  );

  assign bus.imem_req    = w_issue;
  assign bus.imem_addr   = w_issue ? r_pc : '0;
  assign bus.instr_valid = !w_empty;
  assign bus.instr       = w_empty ? '0 : w_head.instr;
  assign bus.instr_pc    = w_empty ? '0 : w_head.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit against a queue-based model of the
// fetch stream, with directed latency, stall and redirect scenarios.
module tb_instr_fetch_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       fetch_en;
  logic       redirect;
  logic [7:0] redirect_pc;

  instr_fetch_unit_if bus ();

  instr_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_en    (fetch_en),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // Instruction memory: word at address a holds a+0x10, one cycle latency.
  always @(posedge clk) bus.imem_rdata <= bus.imem_addr + 8'h10;

  int n_cmp = 0;
  int n_bad = 0;
  int n_req = 0;

  bit         m_run;
  logic [7:0] m_pc;
  bit         m_inflight;
  logic [7:0] m_inf_pc;
  logic [7:0] m_q[$];

  bit         s_valid;
  logic [7:0] s_pc;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: compare outputs at negedge against the model, then advance it.
  task automatic step();
    bit         pop, ereq, evalid;
    logic [7:0] eaddr, epc, einstr;
    @(negedge clk);
    s_valid = bus.instr_valid;
    s_pc    = bus.instr_pc;
    if (rst) begin
      m_run = 0; m_pc = 8'h00; m_inflight = 0; m_q.delete();
    end else begin
      evalid = (m_q.size() > 0);
      pop    = evalid && bus.instr_ready;
      ereq   = m_run && !redirect && ((m_q.size() + int'(m_inflight) - int'(pop)) < 4);
      eaddr  = ereq ? m_pc : 8'h00;
      epc    = evalid ? m_q[0] : 8'h00;
      einstr = evalid ? m_q[0] + 8'h10 : 8'h00;
      check_val("imem_req",    32'(bus.imem_req),    32'(ereq));
      check_val("imem_addr",   32'(bus.imem_addr),   32'(eaddr));
      check_val("instr_valid", 32'(bus.instr_valid), 32'(evalid));
      check_val("instr_pc",    32'(bus.instr_pc),    32'(epc));
      check_val("instr",       32'(bus.instr),       32'(einstr));
      if (bus.imem_req) n_req++;
      if (pop) void'(m_q.pop_front());
      if (redirect) begin
        m_q.delete();
        m_inflight = 0;
        m_pc       = redirect_pc;
      end else begin
        if (m_inflight) m_q.push_back(m_inf_pc);
        m_inflight = ereq;
        if (ereq) begin
          m_inf_pc = m_pc;
          m_pc     = m_pc + 8'h01;
        end
      end
      m_run = fetch_en;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; fetch_en = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
    bus.instr_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int first;
    logic [7:0] head_pc;

    // Reset state, then first valid three cycles after fetch_en with reset released.
    do_reset();
    fetch_en = 1'b1;
    first = -1;
    for (int c = 0; c < 12; c++) begin
      step();
      if (s_valid && first < 0) first = c;
    end
    check_val("first_valid_cycle", 32'(first), 32'd3);

    // Stall from reset: four issues fill the buffer, head holds still.
    do_reset();
    fetch_en = 1'b1;
    bus.instr_ready = 1'b0;
    n_req = 0;
    head_pc = 8'hxx;
    for (int c = 0; c < 12; c++) begin
      step();
      if (c == 4) head_pc = s_pc;
    end
    check_val("stall_issues", 32'(n_req), 32'd4);
    check_val("stall_head_pc", 32'(s_pc), 32'(head_pc));
    bus.instr_ready = 1'b1;
    for (int c = 0; c < 10; c++) step();

    // Redirect while a fetch is in flight.
    redirect = 1'b1; redirect_pc = 8'h40;
    first = -1;
    for (int c = 0; c < 8; c++) begin
      step();
      redirect = 1'b0;
      if (s_valid && s_pc == 8'h40 && first < 0) first = c;
    end
    check_val("redirect_latency", 32'(first), 32'd3);

    // Redirect near the top of the address space: PC wraps FF -> 00.
    redirect = 1'b1; redirect_pc = 8'hFE;
    step();
    redirect = 1'b0;
    for (int c = 0; c < 8; c++) step();

    // Reset mid-stream with a fetch in flight.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 0; c < 8; c++) step();

    // Fill, stop fetching, drain, resume.
    bus.instr_ready = 1'b0;
    for (int c = 0; c < 6; c++) step();
    fetch_en = 1'b0;
    step();
    bus.instr_ready = 1'b1;
    n_req = 0;
    for (int c = 0; c < 6; c++) step();
    check_val("idle_no_req", 32'(n_req), 32'd0);
    fetch_en = 1'b1;
    for (int c = 0; c < 8; c++) step();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      rst             = ($urandom_range(0, 199) == 0);
      fetch_en        = ($urandom_range(0, 9) != 0);
      bus.instr_ready = ($urandom_range(0, 9) < 7);
      redirect        = ($urandom_range(0, 29) == 0);
      redirect_pc     = 8'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
